// File: rtl/qspi_read_sequencer.sv
// rtl/qspi_read_sequencer.sv - quad-I/O fast-read (0xEB) sequencer streaming nibbles into a FIFO
// Optional continuous-read mode (mode byte 0xA0, CMD skipped on follow-up reads): define QSPI_CONT_READ_EN.
module qspi_read_sequencer #(
    parameter int DUMMY_CYCLES = 6,
    parameter int LEN_W        = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             fifo_clear,
    output logic             fifo_push,
    output logic [3:0]       fifo_push_data,
    input  logic             fifo_full,
    output logic             spi_cs_n,
    output logic             spi_sck,
    output logic [3:0]       spi_io_out,
    output logic [3:0]       spi_io_oe,
    input  logic [3:0]       spi_io_in
);
    localparam logic [7:0] CMD_BYTE = 8'hEB;
`ifdef QSPI_CONT_READ_EN
    localparam logic [7:0] MODE_BYTE = 8'hA0;
`else
    localparam logic [7:0] MODE_BYTE = 8'hFF;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, DESEL} state_t;

    state_t           state, state_d;
    logic [3:0]       cyc, cyc_d;
    logic [LEN_W-1:0] len_cnt, len_d;
    logic [23:0]      addr_q, addr_d;
    logic             aborted, aborted_d;
    logic             cs_n_d, sck_d, busy_d, done_d, clear_d, push_d;
    logic [3:0]       out_d, oe_d, pdata_d;
`ifdef QSPI_CONT_READ_EN
    logic             cont_mode, cont_mode_d;
`endif

    function automatic logic [3:0] phase_last(input state_t st);
        case (st)
            CMD:     return 4'd7;
            ADDR:    return 4'd5;
            MODE:    return 4'd1;
            default: return 4'(DUMMY_CYCLES - 1);
        endcase
    endfunction

    function automatic state_t phase_next(input state_t st);
        case (st)
            CMD:     return ADDR;
            ADDR:    return MODE;
            MODE:    return DUMMY;
            default: return DATA;
        endcase
    endfunction

    // {oe, out} presented during serial slot idx of a header phase
    function automatic logic [7:0] phase_drive(input state_t st, input logic [3:0] idx,
                                               input logic [23:0] a);
        case (st)
            CMD:     return {4'b0001, 3'b000, CMD_BYTE[3'(4'd7 - idx)]};
            ADDR:    return {4'b1111, a[5'(6'd23 - {idx, 2'b00}) -: 4]};
            MODE:    return {4'b1111, idx[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4]};
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d   = state;
        cyc_d     = cyc;
        len_d     = len_cnt;
        addr_d    = addr_q;
        aborted_d = aborted;
        cs_n_d    = spi_cs_n;
        sck_d     = spi_sck;
        out_d     = spi_io_out;
        oe_d      = spi_io_oe;
        busy_d    = busy;
        done_d    = 1'b0;
        clear_d   = 1'b0;
        push_d    = 1'b0;
        pdata_d   = fifo_push_data;
`ifdef QSPI_CONT_READ_EN
        cont_mode_d = cont_mode;
`endif
        if (abort && state != IDLE && state != DESEL) begin
            state_d   = DESEL;
            cyc_d     = 4'd0;
            cs_n_d    = 1'b1;
            sck_d     = 1'b0;
            oe_d      = 4'd0;
            out_d     = 4'd0;
            aborted_d = 1'b1;
`ifdef QSPI_CONT_READ_EN
            cont_mode_d = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && len != '0) begin
                        addr_d    = addr;
                        len_d     = len;
                        clear_d   = 1'b1;
                        busy_d    = 1'b1;
                        cs_n_d    = 1'b0;
                        sck_d     = 1'b0;
                        cyc_d     = 4'd0;
                        aborted_d = 1'b0;
`ifdef QSPI_CONT_READ_EN
                        state_d = cont_mode ? ADDR : CMD;
`else
                        state_d = CMD;
`endif
                        {oe_d, out_d} = phase_drive(state_d, 4'd0, addr);
                    end
                end
                CMD, ADDR, MODE, DUMMY: begin
                    if (!spi_sck) begin
                        sck_d = 1'b1;
                    end else begin
                        // falling SCK edge: advance to the next serial slot
                        sck_d = 1'b0;
                        if (cyc == phase_last(state)) begin
                            state_d = phase_next(state);
                            cyc_d   = 4'd0;
`ifdef QSPI_CONT_READ_EN
                            if (state == MODE) cont_mode_d = 1'b1;
`endif
                        end else begin
                            cyc_d = cyc + 4'd1;
                        end
                        {oe_d, out_d} = phase_drive(state_d, cyc_d, addr_q);
                    end
                end
                DATA: begin
                    if (spi_sck) begin
                        sck_d   = 1'b0;
                        push_d  = 1'b1;
                        pdata_d = spi_io_in;
                        len_d   = len_cnt - LEN_W'(1);
                    end else if (len_cnt == '0) begin
                        state_d = DESEL;
                        cyc_d   = 4'd0;
                        cs_n_d  = 1'b1;
                    end else if (!fifo_full && !fifo_push) begin
                        sck_d = 1'b1;
                    end
                end
                DESEL: begin
                    if (cyc == 4'd1) begin
                        state_d = IDLE;
                        cyc_d   = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = !aborted;
                    end else begin
                        cyc_d = cyc + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cyc            <= 4'd0;
            len_cnt        <= '0;
            addr_q         <= 24'd0;
            aborted        <= 1'b0;
            spi_cs_n       <= 1'b1;
            spi_sck        <= 1'b0;
            spi_io_out     <= 4'd0;
            spi_io_oe      <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fifo_clear     <= 1'b0;
            fifo_push      <= 1'b0;
            fifo_push_data <= 4'd0;
`ifdef QSPI_CONT_READ_EN
            cont_mode      <= 1'b0;
`endif
        end else begin
            state          <= state_d;
            cyc            <= cyc_d;
            len_cnt        <= len_d;
            addr_q         <= addr_d;
            aborted        <= aborted_d;
            spi_cs_n       <= cs_n_d;
            spi_sck        <= sck_d;
            spi_io_out     <= out_d;
            spi_io_oe      <= oe_d;
            busy           <= busy_d;
            done           <= done_d;
            fifo_clear     <= clear_d;
            fifo_push      <= push_d;
            fifo_push_data <= pdata_d;
`ifdef QSPI_CONT_READ_EN
            cont_mode      <= cont_mode_d;
`endif
        end
    end
endmodule

// File: tb/tb_qspi_read_sequencer.sv
// tb/tb_qspi_read_sequencer.sv - directed self-checking bench for qspi_read_sequencer
module tb_qspi_read_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, abort, fifo_full;
    logic [23:0] addr;
    logic [6:0]  len;
    logic        busy, done, fifo_clear, fifo_push;
    logic [3:0]  fifo_push_data;
    logic        spi_cs_n, spi_sck;
    logic [3:0]  spi_io_out, spi_io_oe;
    logic [3:0]  spi_io_in = 4'h0;

    always #5 clk = ~clk;

    qspi_read_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len), .abort(abort),
        .busy(busy), .done(done), .fifo_clear(fifo_clear), .fifo_push(fifo_push),
        .fifo_push_data(fifo_push_data), .fifo_full(fifo_full), .spi_cs_n(spi_cs_n),
        .spi_sck(spi_sck), .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in)
    );

`ifdef QSPI_CONT_READ_EN
    localparam logic [7:0] MODE_EXP = 8'hA0;
`else
    localparam logic [7:0] MODE_EXP = 8'hFF;
`endif
    localparam logic [17:0] RST_OUTS = {1'b1, 17'd0};

    int         clear_cnt = 0, done_cnt = 0, busy_cyc = 0, csl_cyc = 0;
    int         txn_rise = 0, hdr = 22;
    logic       sck_prev = 1'b0;
    logic [7:0] io_log[$];
    logic [3:0] push_log[$];

    // Bus monitor plus flash model: data nibble k answers the k-th SCK after the header
    always @(negedge clk) begin
        if (fifo_clear) clear_cnt++;
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (!spi_cs_n) csl_cyc++;
        if (fifo_push) push_log.push_back(fifo_push_data);
        if (spi_sck && !sck_prev) begin
            io_log.push_back({spi_io_oe, spi_io_out});
            if (txn_rise == 0) hdr = (spi_io_oe == 4'b0001) ? 22 : 14;
            if (txn_rise >= hdr) spi_io_in = 4'(txn_rise - hdr);
            txn_rise++;
        end
        if (spi_cs_n) txn_rise = 0;
        sck_prev = spi_sck;
    end

    int passed = 0, total = 0, fails = 0;
    int b_io, b_push, b_clr, b_done, b_busy, b_csl, k, hi, p0, r0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_io = io_log.size(); b_push = push_log.size(); b_clr = clear_cnt;
        b_done = done_cnt; b_busy = busy_cyc; b_csl = csl_cyc;
    endtask

    task automatic start_txn(input logic [23:0] a, input logic [6:0] l);
        start = 1'b1; addr = a; len = l;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin tick(1); n++; end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_rises(input string tag, input int cnt);
        int n = 0;
        while (io_log.size() - b_io < cnt && n < 1000) begin tick(1); n++; end
        check(tag, io_log.size() - b_io >= cnt, 1'b1);
    endtask

    task automatic wait_pushes(input string tag, input int cnt);
        int n = 0;
        while (push_log.size() - b_push < cnt && n < 1000) begin tick(1); n++; end
        check(tag, push_log.size() - b_push, cnt);
    endtask

    function automatic logic [7:0] rise_at(input int i);
        if (i < io_log.size()) return io_log[i];
        return 8'hxx;
    endfunction

    function automatic logic [31:0] push_word(input int base, input int cnt);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < cnt; i++)
            w = {w[27:0], (base + i < push_log.size()) ? push_log[base + i] : 4'hx};
        return w;
    endfunction

    function automatic logic [31:0] nib_word(input int base, input int cnt);
        logic [31:0] w = 32'd0;
        logic [7:0]  r;
        for (int i = 0; i < cnt; i++) begin
            r = rise_at(base + i);
            w = {w[27:0], r[3:0]};
        end
        return w;
    endfunction

    function automatic logic [7:0] cmd_bits(input int base);
        logic [7:0] c = 8'd0;
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r = rise_at(base + i);
            c = {c[6:0], r[0]};
        end
        return c;
    endfunction

    function automatic logic [17:0] outs();
        return {spi_cs_n, spi_sck, spi_io_oe, spi_io_out, busy, done,
                fifo_clear, fifo_push, fifo_push_data};
    endfunction

    initial begin
        logic [7:0] r;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; fifo_full = 1'b0; addr = 24'd0; len = 7'd0;
        tick(2);
        check("reset_outputs", outs(), RST_OUTS);
        rst_n = 1'b1;
        tick(2);

        // normal read
        snap();
        start_txn(24'h123456, 7'd8);
        check("normal_busy", busy, 1'b1);
        wait_idle("normal_idle");
        check("normal_clear_once", clear_cnt - b_clr, 1);
        check("normal_cmd", cmd_bits(b_io), 8'hEB);
        r = rise_at(b_io);
        check("normal_cmd_oe", r[7:4], 4'b0001);
        check("normal_addr", nib_word(b_io + 8, 6), 32'h00123456);
        check("normal_mode", nib_word(b_io + 14, 2), {24'd0, MODE_EXP});
        hi = 0;
        for (int i = 16; i < 22; i++) begin
            r = rise_at(b_io + i);
            if (r[7:4] == 4'd0) hi++;
        end
        check("normal_dummy_oe0", hi, 6);
        check("normal_sck_total", io_log.size() - b_io, 30);
        check("normal_push_cnt", push_log.size() - b_push, 8);
        check("normal_push_data", push_word(b_push, 8), 32'h01234567);
        check("normal_done_once", done_cnt - b_done, 1);
        check("normal_cs_high", spi_cs_n, 1'b1);

        // backpressure, with an ignored start during DUMMY
        snap();
        start_txn(24'h123456, 7'd8);
        wait_rises("bp_reach_dummy", 17);
        start = 1'b1; addr = 24'hABCDEF; len = 7'd3;
        tick(1);
        start = 1'b0;
        wait_pushes("bp_reach_push3", 3);
        fifo_full = 1'b1;
        r0 = io_log.size(); p0 = push_log.size(); hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (spi_sck) hi++;
        end
        fifo_full = 1'b0;
        check("bp_sck_low", hi, 0);
        check("bp_no_rise", io_log.size() - r0, 0);
        check("bp_no_push", push_log.size() - p0, 0);
        wait_idle("bp_idle");
        check("bp_push_cnt", push_log.size() - b_push, 8);
        check("bp_push_data", push_word(b_push, 8), 32'h01234567);
        check("bp_clear_once", clear_cnt - b_clr, 1);
        check("bp_addr_kept", dut.addr_q, 24'h123456);
        check("bp_done_once", done_cnt - b_done, 1);

        // abort in DATA after two pushes
        snap();
        start_txn(24'h000100, 7'd8);
        wait_pushes("abort_reach_push2", 2);
        abort = 1'b1;
        r0 = io_log.size();
        tick(1);
        abort = 1'b0;
        check("abort_cs_high", spi_cs_n, 1'b1);
        check("abort_sck_low", spi_sck, 1'b0);
        check("abort_oe_off", spi_io_oe, 4'd0);
        tick(3);
        check("abort_busy_low", busy, 1'b0);
        check("abort_no_sck", io_log.size() - r0, 0);
        check("abort_push_cnt", push_log.size() - b_push, 2);
        check("abort_push_data", push_word(b_push, 2), 32'h00000001);
        check("abort_no_done", done_cnt - b_done, 0);

        // start with len==0 is ignored
        snap();
        start_txn(24'h123456, 7'd0);
        tick(5);
        check("len0_no_busy", busy_cyc - b_busy, 0);
        check("len0_no_cs", csl_cyc - b_csl, 0);
        check("len0_no_clear", clear_cnt - b_clr, 0);

        // reset during ADDR, then a start that coincides with abort
        snap();
        start_txn(24'h123456, 7'd8);
        wait_rises("rst_reach_addr", 10);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", outs(), RST_OUTS);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        snap();
        abort = 1'b1;
        start_txn(24'h654321, 7'd4);
        abort = 1'b0;
        wait_idle("rst_next_idle");
        check("rst_next_cmd", cmd_bits(b_io), 8'hEB);
        check("rst_next_addr", nib_word(b_io + 8, 6), 32'h00654321);
        check("rst_next_push", push_word(b_push, 4), 32'h00000123);
        check("rst_next_done", done_cnt - b_done, 1);

`ifdef QSPI_CONT_READ_EN
        // continuous mode: previous read left cont_mode set
        snap();
        start_txn(24'h000010, 7'd2);
        wait_idle("cont_idle");
        r = rise_at(b_io);
        check("cont_first_oe", r[7:4], 4'b1111);
        check("cont_addr", nib_word(b_io, 6), 32'h00000010);
        check("cont_sck_total", io_log.size() - b_io, 16);
        check("cont_push_data", push_word(b_push, 2), 32'h00000001);
        snap();
        start_txn(24'h000200, 7'd8);
        wait_rises("cont_abort_reach", 3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_idle("cont_abort_idle");
        snap();
        start_txn(24'h000020, 7'd1);
        wait_idle("cont_after_abort_idle");
        check("cont_after_abort_cmd", cmd_bits(b_io), 8'hEB);
        check("cont_after_abort_total", io_log.size() - b_io, 23);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/qspi_read_sequencer.md
Name: qspi_read_sequencer

Overview:
Sequences quad-I/O fast-read transactions (command 0xEB) to an external QSPI flash and streams the returned nibbles into the qspi_fifo push port. The block generates CS#/SCK, drives the command, address, mode and dummy phases, and captures data nibbles. It stalls SCK whenever the FIFO cannot accept data, so the downstream 2-bit consumer sets the effective read rate.

Parameters:
DUMMY_CYCLES, 6, number of SCK cycles in the dummy phase (1..15)
LEN_W, 7, width of the transfer-length field, in nibbles

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request pulse; sampled only in IDLE
addr  input  24  flash byte address; latched on accepted start
len  input  LEN_W  nibbles to read; latched on accepted start
abort  input  1  terminate the current transaction
busy  output  1  transaction in progress
done  output  1  one-cycle pulse on normal completion
fifo_clear  output  1  one-cycle pulse to the FIFO on accepted start
fifo_push  output  1  push strobe to the FIFO
fifo_push_data  output  4  captured nibble
fifo_full  input  1  FIFO full flag
spi_cs_n  output  1  flash chip select, active-low
spi_sck  output  1  flash clock, idle low
spi_io_out  output  4  IO output values
spi_io_oe  output  4  IO output enables
spi_io_in  input  4  IO input values

Behaviour:
- Reset values: spi_cs_n=1, spi_sck=0, spi_io_oe=0, spi_io_out=0, busy=0, done=0, fifo_clear=0, fifo_push=0, fifo_push_data=0. All registers are cleared asynchronously. A reset that asserts mid-transaction returns the block to IDLE immediately.
- States: IDLE -> CMD -> ADDR -> MODE -> DUMMY -> DATA -> DESEL -> IDLE.
- IDLE:
  - A start with len!=0 is accepted: the block latches addr and len, pulses fifo_clear, and sets busy.
  - The next cycle drives spi_cs_n=0 and enters CMD.
  - A start with len==0 is ignored: no busy, no done.
  - start outside IDLE is ignored.
- SCK timing:
  - Outside DATA, each SCK period is 2 clk: one low cycle, then one high cycle.
  - Outputs change only on the clk edge that drives SCK low.
- CMD: 8 SCK. 0xEB is sent MSB first on io[0]. spi_io_oe=4'b0001 and io[3:1] are driven 0.
- ADDR: 6 SCK. Address nibbles are sent addr[23:20] first. spi_io_oe=4'b1111.
- MODE: 2 SCK. The mode byte is sent high nibble first, with spi_io_oe=4'b1111. The mode byte is 0xFF unless the optional feature is enabled.
- DUMMY: DUMMY_CYCLES SCK with spi_io_oe=0.
- DATA: spi_io_oe=0.
  - spi_io_in is captured on the clk edge where SCK goes from 1 to 0.
  - In the next cycle, fifo_push=1 and fifo_push_data=captured nibble.
  - SCK may rise only in a cycle where fifo_full==0 and fifo_push==0. Otherwise SCK is held low (stall). This gives a minimum of 3 clk per nibble.
  - The nibble counter decrements on each capture. After the final push, the block enters DESEL.
- DESEL:
  - spi_cs_n=1 and SCK stays low for 2 clk.
  - A normal completion then pulses done for 1 clk, and busy falls in that same cycle.
- abort:
  - Accepted in any state other than IDLE or DESEL.
  - Effects: SCK goes low next cycle, cs_n goes high next cycle, oe=0, and any pending push still completes.
  - The block then enters DESEL, and no done pulse is issued.
  - abort and start in the same IDLE cycle: start wins and abort is ignored.
- busy=1 from the accepted start through DESEL.

Optional Feature:
QSPI_CONT_READ_EN
- Defined:
  - MODE sends 0xA0 and sets a cont_mode flag at the end of MODE.
  - While cont_mode=1, the next transaction skips CMD and starts at ADDR.
  - cont_mode is cleared by reset and by abort, so the command is resent afterwards.
- Undefined: the mode byte is always 0xFF, every transaction starts with CMD, and no cont_mode flag exists.

Test Plan:
- Normal read: start with addr=0x123456, len=8; the flash model returns nibbles 0..7.
  - Required: fifo_clear pulses once.
  - Required: io[0] carries 1,1,1,0,1,0,1,1 over 8 SCK, then address nibbles 1,2,3,4,5,6, then mode nibbles F,F, then 6 dummy SCK.
  - Required: 8 pushes carry data 0..7, cs_n rises, and done pulses exactly once.
- Backpressure: same transfer, with fifo_full forced to 1 after the 3rd push for 20 clk.
  - Required: SCK stays low and there are no pushes while full is high.
  - Required: pushes resume with nibble 3 and total 8 pushes.
- Abort in DATA after 2 pushes.
  - Required: cs_n=1 within 1 clk and no further SCK edges.
  - Required: exactly 2 pushes, no done, busy low after DESEL.
- Ignored requests.
  - Required: start with len=0 produces no busy and no cs_n activity.
  - Required: a second start during DUMMY leaves the latched addr and len unchanged.
- Reset in ADDR phase (rst_n low for 1 clk).
  - Required: all outputs take their reset values immediately.
  - Required: the next start begins again at CMD.
- With QSPI_CONT_READ_EN: two back-to-back reads.
  - Required: the first sends mode 0xA0.
  - Required: the second starts at ADDR with no CMD SCKs.
  - Required: after an abort, the next read sends CMD again.
